// File: rtl/rst_domain_sequencer.sv
// Sequenced reset controller: holds every domain in reset, then releases them
// in index order, waiting for each domain's ack plus a gap before the next.
module rst_domain_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255,
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES,
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT,
  localparam int CNT_W   = $clog2(MAX_CNT + 1),
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       err_domain
);

  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, DONE, ERROR} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cur_ack;

  // Only the ack of the domain currently being waited on matters.
  always_comb begin
    cur_ack = 1'b0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (k == int'(idx)) cur_ack = domain_ack[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      domain_rst_n <= '0;
      seq_busy     <= 1'b1;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
      err_domain   <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (k == int'(idx)) domain_rst_n[k] <= 1'b1;
          end
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack on the timeout boundary cycle still wins over the error.
          if (cur_ack) begin
            if (idx == IDX_LAST) begin
              state    <= DONE;
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
            end else if (GAP_CYCLES == 0) begin
              state <= RELEASE;
              idx   <= idx + IDX_W'(1);
            end else begin
              state <= GAP;
              cnt   <= '0;
            end
          end else if (cnt == ACK_LAST) begin
            state       <= ERROR;
            timeout_err <= 1'b1;
            err_domain  <= idx;
            seq_busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= RELEASE;
            idx   <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE, ERROR: state <= state;
        default: state <= HOLD;
      endcase
    end
  end

endmodule
